// File: rtl/seq_match_window_ctrl.sv
// Windowed 1011-style sequence match counter with valid/ready result hold.
// Optional macro AUTO_RESTART_EN: the HOLD handshake re-arms RUN with the latched length.
module seq_match_window_ctrl #(
   parameter int         N       = 8,
   parameter int         WIN_W   = 10,
   parameter logic [3:0] PATTERN = 4'b1011
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             din,
   input  logic             din_valid,
   input  logic             rd_ready,
   output logic             busy,
   output logic             result_valid,
   output logic [N-1:0]     match_cnt,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [N-1:0]     CNT_MAX = {N{1'b1}};
   localparam logic [N-1:0]     CNT_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   logic [WIN_W-1:0] r_win_len;
   logic [WIN_W-1:0] r_smp_cnt;
   logic [3:0]       r_hist;
   logic [1:0]       r_fill;
   logic [N-1:0]     r_match_cnt;
   logic             r_overflow;
   logic             r_busy;
   logic             r_result_valid;

   logic             w_start_ok;
   logic             w_run_smp;
   logic             w_match;
   logic             w_last;
   logic             w_handshake;
   logic             w_clear;

   assign w_start_ok  = (r_state == S_IDLE) && start && (win_len != {WIN_W{1'b0}});
   assign w_run_smp   = (r_state == S_RUN) && din_valid;
   // r_fill saturates at 3: three prior samples plus din make a full 4-bit window.
   assign w_match     = w_run_smp && (r_fill == 2'd3) && ({r_hist[2:0], din} == PATTERN);
   assign w_last      = w_run_smp && (r_smp_cnt == (r_win_len - WIN_ONE));
   assign w_handshake = (r_state == S_HOLD) && rd_ready;

`ifdef AUTO_RESTART_EN
   assign w_clear = w_start_ok || w_handshake;
`else
   assign w_clear = w_start_ok;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next_state = S_HOLD;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_HOLD: begin
            if (w_handshake) begin
`ifdef AUTO_RESTART_EN
               w_next_state = S_RUN;
`else
               w_next_state = S_IDLE;
`endif
            end else begin
               w_next_state = S_HOLD;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they line up with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_busy         <= (w_next_state != S_IDLE);
         r_result_valid <= (w_next_state == S_HOLD);
      end
   end

   // Window datapath: length latch, history, sample and match counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win_len   <= {WIN_W{1'b0}};
         r_smp_cnt   <= {WIN_W{1'b0}};
         r_hist      <= 4'b0000;
         r_fill      <= 2'd0;
         r_match_cnt <= {N{1'b0}};
         r_overflow  <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_win_len <= win_len;
         end
         if (w_clear) begin
            r_smp_cnt   <= {WIN_W{1'b0}};
            r_hist      <= 4'b0000;
            r_fill      <= 2'd0;
            r_match_cnt <= {N{1'b0}};
            r_overflow  <= 1'b0;
         end else if (w_run_smp) begin
            r_hist    <= {r_hist[2:0], din};
            r_smp_cnt <= r_smp_cnt + WIN_ONE;
            if (r_fill != 2'd3) begin
               r_fill <= r_fill + 2'd1;
            end
            if (w_match) begin
               if (r_match_cnt == CNT_MAX) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_match_cnt <= r_match_cnt + CNT_ONE;
               end
            end
         end
      end
   end

   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign match_cnt    = r_match_cnt;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_seq_match_window_ctrl.sv
// Directed bench for seq_match_window_ctrl; a second instance with N=2 covers saturation.
module tb_seq_match_window_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] win_len;
   logic       din;
   logic       din_valid;
   logic       rd_ready;

   logic       busy_a, rv_a, ovf_a;
   logic [7:0] cnt_a;
   logic       busy_b, rv_b, ovf_b;
   logic [1:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_match_window_ctrl #(.N(8), .WIN_W(10), .PATTERN(4'b1011)) u_dut (
      .clk(clk), .reset(reset), .start(start), .win_len(win_len),
      .din(din), .din_valid(din_valid), .rd_ready(rd_ready),
      .busy(busy_a), .result_valid(rv_a), .match_cnt(cnt_a), .overflow(ovf_a)
   );

   seq_match_window_ctrl #(.N(2), .WIN_W(10), .PATTERN(4'b1011)) u_dut_n2 (
      .clk(clk), .reset(reset), .start(start), .win_len(win_len),
      .din(din), .din_valid(din_valid), .rd_ready(rd_ready),
      .busy(busy_b), .result_valid(rv_b), .match_cnt(cnt_b), .overflow(ovf_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      din       = b;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din       = 1'b0;
   endtask

   task automatic open_win(input logic [9:0] len);
      start   = 1'b1;
      win_len = len;
      tick();
      start   = 1'b0;
   endtask

   task automatic do_handshake();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(bits[i]);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; win_len = 10'd0;
      din = 1'b0; din_valid = 1'b0; rd_ready = 1'b0;
      tick();
      check_val("rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("rst_rv",   {31'd0, rv_a},   32'd0);
      check_val("rst_cnt",  {24'd0, cnt_a},  32'd0);
      check_val("rst_ovf",  {31'd0, ovf_a},  32'd0);
      reset = 1'b0;
      tick();

`ifdef AUTO_RESTART_EN
      // Two back-to-back windows; second would match on stale history if not cleared
      open_win(10'd4);
      check_val("ar_busy_run", {31'd0, busy_a}, 32'd1);
      send_bits(16'b1011, 4);
      check_val("ar_rv1",  {31'd0, rv_a},  32'd1);
      check_val("ar_cnt1", {24'd0, cnt_a}, 32'd1);
      do_handshake();
      check_val("ar_busy_hs", {31'd0, busy_a}, 32'd1);
      check_val("ar_rv_hs",   {31'd0, rv_a},   32'd0);
      check_val("ar_cnt_clr", {24'd0, cnt_a},  32'd0);
      send_bits(16'b0111, 4);
      check_val("ar_rv2",   {31'd0, rv_a},   32'd1);
      check_val("ar_cnt2",  {24'd0, cnt_a},  32'd0);
      check_val("ar_busy2", {31'd0, busy_a}, 32'd1);
`else
      // Overlapping matches in an 8-sample window, then a held result ignoring start
      open_win(10'd8);
      check_val("t1_busy", {31'd0, busy_a}, 32'd1);
      check_val("t1_rv0",  {31'd0, rv_a},   32'd0);
      send_bits(16'b10110110, 8);
      check_val("t1_rv",   {31'd0, rv_a},   32'd1);
      check_val("t1_cnt",  {24'd0, cnt_a},  32'd2);
      check_val("t1_ovf",  {31'd0, ovf_a},  32'd0);
      din = 1'b1; din_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      din_valid = 1'b0;
      check_val("t4_rv_hold",  {31'd0, rv_a},  32'd1);
      check_val("t4_cnt_hold", {24'd0, cnt_a}, 32'd2);
      open_win(10'd4);
      check_val("t4_start_ign_rv",  {31'd0, rv_a},  32'd1);
      check_val("t4_start_ign_cnt", {24'd0, cnt_a}, 32'd2);
      do_handshake();
      check_val("t4_idle_rv",   {31'd0, rv_a},   32'd0);
      check_val("t4_idle_busy", {31'd0, busy_a}, 32'd0);
      check_val("t4_keep_cnt",  {24'd0, cnt_a},  32'd2);
      tick();
      check_val("t4_rd_idle",   {31'd0, busy_a}, 32'd0);

      // Saturation: five overlapping matches against N=8 and N=2 counters
      open_win(10'd16);
      check_val("t2_cnt_clr", {24'd0, cnt_a}, 32'd0);
      send_bits(16'b1011011011011011, 16);
      check_val("t2_rv",     {31'd0, rv_b},  32'd1);
      check_val("t2_cnt_n2", {30'd0, cnt_b}, 32'd3);
      check_val("t2_ovf_n2", {31'd0, ovf_b}, 32'd1);
      check_val("t2_cnt_n8", {24'd0, cnt_a}, 32'd5);
      check_val("t2_ovf_n8", {31'd0, ovf_a}, 32'd0);
      do_handshake();

      // Samples separated by invalid gaps
      open_win(10'd4);
      check_val("t3_ovf_clr", {30'd0, ovf_b}, 32'd0);
      for (int i = 3; i >= 0; i--) begin
         send_bit(i[0] ? 1'b1 : (i == 2 ? 1'b0 : 1'b1));
         if (i != 0) begin
            tick(); tick(); tick();
         end
         if (i == 1) begin
            check_val("t3_rv_early", {31'd0, rv_a}, 32'd0);
         end
      end
      check_val("t3_rv",  {31'd0, rv_a},  32'd1);
      check_val("t3_cnt", {24'd0, cnt_a}, 32'd1);
      do_handshake();

      // Zero-length start is ignored
      open_win(10'd0);
      check_val("t5_busy_zero", {31'd0, busy_a}, 32'd0);
      tick();
      check_val("t5_busy_zero2", {31'd0, busy_a}, 32'd0);

      // Maximum length window of zeros
      open_win(10'd1023);
      for (int i = 0; i < 1022; i++) send_bit(1'b0);
      check_val("max_not_done", {31'd0, rv_a}, 32'd0);
      send_bit(1'b0);
      check_val("max_done",     {31'd0, rv_a}, 32'd1);
      check_val("max_cnt",      {24'd0, cnt_a}, 32'd0);
      do_handshake();

      // Asynchronous reset mid-window
      open_win(10'd5);
      send_bits(16'b101, 3);
      send_bit(1'b1);
      check_val("t5_pre_cnt", {24'd0, cnt_a}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check_val("t5_arst_busy", {31'd0, busy_a}, 32'd0);
      check_val("t5_arst_rv",   {31'd0, rv_a},   32'd0);
      check_val("t5_arst_cnt",  {24'd0, cnt_a},  32'd0);
      check_val("t5_arst_ovf",  {31'd0, ovf_b},  32'd0);
      tick();
      reset = 1'b0;
      tick();
      check_val("t5_post_busy", {31'd0, busy_a}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
